// File: rtl/deskew_reg_file.sv
// deskew_reg_file
// Register bank between the AXI-lite bridge and the deskew core. Decodes the
// bridge's single-cycle strobes, holds the core configuration, issues start
// pulses, captures completion, keeps sticky W1C status, runs a busy watchdog
// and drives a registered level interrupt.
//
// Register map (byte addresses, word aligned, upper address bits must be 0):
//   0x00 CTRL     RW  [0] enable, [1] start (write-1 pulse, reads 0), [2] irq_en
//   0x04 STATUS       [0] busy RO, [1] done W1C, [2] timeout W1C, [3] start_ovr W1C
//   0x08 SKEW_CFG RW  [7:0]
//   0x0C THRESH   RW  [15:0]
//   0x10 RESULT   RO  [31:0]
//
// Ports:
//   axis_clk, axis_rst      clock, synchronous active-high reset
//   write_reg/reg_waddr/reg_wdata   one-cycle write strobe, address, data
//   read_reg/reg_raddr      read strobe (may be held), address
//   reg_rdata               registered read data, loaded on each read_reg edge
//   core_enable/core_start/core_skew/core_thresh   configuration to the core
//   core_done/core_result   one-cycle completion pulse and its result word
//   irq                     irq_en & (done | timeout | start_ovr), registered
//
// Handshake: the bridge strobes are qualified only by write_reg/read_reg; there
// is no back-pressure. A write takes effect on the edge where write_reg=1; a
// read returns the register values as they were before that edge.

module deskew_reg_file #(
    parameter int REG_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                      axis_clk,
    input  logic                      axis_rst,
    input  logic                      write_reg,
    input  logic [REG_ADDR_WIDTH-1:0] reg_waddr,
    input  logic [31:0]               reg_wdata,
    input  logic                      read_reg,
    input  logic [REG_ADDR_WIDTH-1:0] reg_raddr,
    output logic [31:0]               reg_rdata,
    output logic                      core_enable,
    output logic                      core_start,
    output logic [7:0]                core_skew,
    output logic [15:0]               core_thresh,
    input  logic                      core_done,
    input  logic [31:0]               core_result,
    output logic                      irq
);

    localparam logic [19:0] WD_LIMIT = 20'(TIMEOUT_CYCLES - 1);

    logic        r_enable;
    logic        r_irq_en;
    logic [7:0]  r_skew;
    logic [15:0] r_thresh;
    logic [31:0] r_result;
    logic        r_busy;
    logic        r_done;
    logic        r_timeout;
    logic        r_start_ovr;
    logic [19:0] r_wd;
    logic        r_start;
    logic        r_irq;
    logic [31:0] r_rdata;

    logic        w_waddr_ok;
    logic        w_raddr_ok;
    logic        w_wr_ctrl;
    logic        w_wr_status;
    logic        w_wr_skew;
    logic        w_wr_thresh;
    logic        w_start_req;
    logic        w_start_go;
    logic        w_ovr_set;
    logic        w_done_evt;
    logic        w_disable;
    logic        w_timeout_evt;
    logic [31:0] w_rmux;
    logic        w_unused;

    // Only word-aligned addresses with every bit above [4:2] clear decode.
    assign w_waddr_ok = (reg_waddr[1:0] == 2'b00) && ((reg_waddr >> 5) == '0);
    assign w_raddr_ok = (reg_raddr[1:0] == 2'b00) && ((reg_raddr >> 5) == '0);

    assign w_wr_ctrl   = write_reg && w_waddr_ok && (reg_waddr[4:2] == 3'd0);
    assign w_wr_status = write_reg && w_waddr_ok && (reg_waddr[4:2] == 3'd1);
    assign w_wr_skew   = write_reg && w_waddr_ok && (reg_waddr[4:2] == 3'd2);
    assign w_wr_thresh = write_reg && w_waddr_ok && (reg_waddr[4:2] == 3'd3);

    // A start request needs the enable bit carried in the same CTRL write.
    assign w_start_req = w_wr_ctrl && reg_wdata[1] && reg_wdata[0];
    assign w_start_go  = w_start_req && !r_busy;
    assign w_ovr_set   = w_start_req && r_busy;

    // Job-end priority: core completion, then software disable, then watchdog.
    assign w_done_evt    = core_done && r_busy;
    assign w_disable     = w_wr_ctrl && !reg_wdata[0] && r_busy && !core_done;
    assign w_timeout_evt = r_busy && !core_done && !w_disable && (r_wd == WD_LIMIT);

    assign w_unused = ^reg_wdata[31:16];

    always_comb begin
        w_rmux = '0;
        if (w_raddr_ok) begin
            case (reg_raddr[4:2])
                3'd0:    w_rmux = {29'd0, r_irq_en, 1'b0, r_enable};
                3'd1:    w_rmux = {28'd0, r_start_ovr, r_timeout, r_done, r_busy};
                3'd2:    w_rmux = {24'd0, r_skew};
                3'd3:    w_rmux = {16'd0, r_thresh};
                3'd4:    w_rmux = r_result;
                default: w_rmux = '0;
            endcase
        end
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            r_enable    <= 1'b0;
            r_irq_en    <= 1'b0;
            r_skew      <= '0;
            r_thresh    <= '0;
            r_result    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_start_ovr <= 1'b0;
            r_wd        <= '0;
            r_start     <= 1'b0;
            r_irq       <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_start <= w_start_go;

            if (w_wr_ctrl) begin
                r_enable <= reg_wdata[0];
                r_irq_en <= reg_wdata[2];
            end
            if (w_wr_skew) begin
                r_skew <= reg_wdata[7:0];
            end
            if (w_wr_thresh) begin
                r_thresh <= reg_wdata[15:0];
            end

            // Job tracking. Every end event requires busy, so a start (which
            // requires !busy) never collides with them. The watchdog holds its
            // value once busy drops, so it cannot wrap.
            if (w_done_evt) begin
                r_busy   <= 1'b0;
                r_result <= core_result;
            end else if (w_disable || w_timeout_evt) begin
                r_busy <= 1'b0;
            end else if (w_start_go) begin
                r_busy <= 1'b1;
                r_wd   <= '0;
            end else if (r_busy) begin
                r_wd <= r_wd + 20'd1;
            end

            // Sticky flags: a set in the same cycle wins over a W1C.
            r_done      <= w_done_evt    || (r_done      && !(w_wr_status && reg_wdata[1]));
            r_timeout   <= w_timeout_evt || (r_timeout   && !(w_wr_status && reg_wdata[2]));
            r_start_ovr <= w_ovr_set     || (r_start_ovr && !(w_wr_status && reg_wdata[3]));

            r_irq <= r_irq_en && (r_done || r_timeout || r_start_ovr);

            if (read_reg) begin
                r_rdata <= w_rmux;
            end
        end
    end

    assign reg_rdata   = r_rdata;
    assign core_enable = r_enable;
    assign core_start  = r_start;
    assign core_skew   = r_skew;
    assign core_thresh = r_thresh;
    assign irq         = r_irq;

endmodule

// File: tb/tb_deskew_reg_file.sv
module tb_deskew_reg_file;

    localparam int T = 16;

    logic        clk;
    logic        rst;
    logic        write_reg;
    logic [31:0] reg_waddr;
    logic [31:0] reg_wdata;
    logic        read_reg;
    logic [31:0] reg_raddr;
    logic [31:0] reg_rdata;
    logic        core_enable;
    logic        core_start;
    logic [7:0]  core_skew;
    logic [15:0] core_thresh;
    logic        core_done;
    logic [31:0] core_result;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 0;

    deskew_reg_file #(
        .REG_ADDR_WIDTH(32),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .axis_clk    (clk),
        .axis_rst    (rst),
        .write_reg   (write_reg),
        .reg_waddr   (reg_waddr),
        .reg_wdata   (reg_wdata),
        .read_reg    (read_reg),
        .reg_raddr   (reg_raddr),
        .reg_rdata   (reg_rdata),
        .core_enable (core_enable),
        .core_start  (core_start),
        .core_skew   (core_skew),
        .core_thresh (core_thresh),
        .core_done   (core_done),
        .core_result (core_result),
        .irq         (irq)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Register state as the register map describes it; job timeout is tracked
    // as an absolute cycle stamp rather than a counter.
    bit          m_enable, m_irq_en, m_busy, m_done, m_to, m_ovr;
    logic [7:0]  m_skew;
    logic [15:0] m_thresh;
    logic [31:0] m_result;
    int          cyc = 0;
    int          start_cyc = 0;
    logic [31:0] e_rdata;
    bit          e_start, e_irq;

    function automatic int reg_index(input logic [31:0] a);
        if ((a % 4) != 0 || a > 32'h10) return -1;
        return int'(a / 4);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        case (reg_index(a))
            0:       return {29'd0, m_irq_en, 1'b0, m_enable};
            1:       return {28'd0, m_ovr, m_to, m_done, m_busy};
            2:       return {24'd0, m_skew};
            3:       return {16'd0, m_thresh};
            4:       return m_result;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin : model
        int wi;
        bit pre_busy;
        bit nirq;
        cyc++;
        if (rst) begin
            m_enable = 0; m_irq_en = 0; m_busy = 0; m_done = 0; m_to = 0; m_ovr = 0;
            m_skew = 0; m_thresh = 0; m_result = 0;
            e_rdata = 0; e_start = 0; e_irq = 0;
        end else begin
            e_start = 0;
            if (read_reg) e_rdata = model_read(reg_raddr);
            nirq = m_irq_en && (m_done || m_to || m_ovr);
            pre_busy = m_busy;
            wi = write_reg ? reg_index(reg_waddr) : -1;
            if (wi == 1) begin
                if (reg_wdata[1]) m_done = 0;
                if (reg_wdata[2]) m_to = 0;
                if (reg_wdata[3]) m_ovr = 0;
            end
            if (pre_busy && core_done) begin
                m_busy = 0; m_done = 1; m_result = core_result;
            end else if (pre_busy && wi == 0 && !reg_wdata[0]) begin
                m_busy = 0;
            end else if (pre_busy && cyc == start_cyc + T) begin
                m_busy = 0; m_to = 1;
            end
            if (wi == 0) begin
                if (reg_wdata[1] && reg_wdata[0]) begin
                    if (pre_busy) m_ovr = 1;
                    else begin
                        m_busy = 1; start_cyc = cyc; e_start = 1;
                    end
                end
                m_enable = reg_wdata[0];
                m_irq_en = reg_wdata[2];
            end
            if (wi == 2) m_skew = reg_wdata[7:0];
            if (wi == 3) m_thresh = reg_wdata[15:0];
            e_irq = nirq;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_rdata",  reg_rdata, e_rdata);
            check("m_enable", {31'd0, core_enable}, {31'd0, m_enable});
            check("m_start",  {31'd0, core_start}, {31'd0, e_start});
            check("m_skew",   {24'd0, core_skew}, {24'd0, m_skew});
            check("m_thresh", {16'd0, core_thresh}, {16'd0, m_thresh});
            check("m_irq",    {31'd0, irq}, {31'd0, e_irq});
        end
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        write_reg = 1; reg_waddr = a; reg_wdata = d;
        @(negedge clk);
        write_reg = 0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        read_reg = 1; reg_raddr = a;
        @(negedge clk);
        read_reg = 0;
        check(name, reg_rdata, exp);
    endtask

    task automatic rw(input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp, input string name);
        write_reg = 1; reg_waddr = a; reg_wdata = d;
        read_reg = 1; reg_raddr = a;
        @(negedge clk);
        write_reg = 0; read_reg = 0;
        check(name, reg_rdata, exp);
    endtask

    task automatic pulse_done(input logic [31:0] r);
        core_done = 1; core_result = r;
        @(negedge clk);
        core_done = 0; core_result = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1; write_reg = 0; reg_waddr = 0; reg_wdata = 0;
        read_reg = 0; reg_raddr = 0; core_done = 0; core_result = 0;
        idle(2);
        rst = 0;
        chk_en = 1;

        // Reset values
        rd(32'h00, 32'h0, "rst_ctrl");
        rd(32'h04, 32'h0, "rst_status");
        rd(32'h08, 32'h0, "rst_skew");
        rd(32'h0C, 32'h0, "rst_thresh");
        rd(32'h10, 32'h0, "rst_result");
        check("rst_irq", {31'd0, irq}, 32'd0);

        // Config registers mask to their widths
        wr(32'h08, 32'hFFFF_FFA5);
        wr(32'h0C, 32'h1234_5678);
        rd(32'h08, 32'h0000_00A5, "rd_skew");
        rd(32'h0C, 32'h0000_5678, "rd_thresh");
        check("core_skew", {24'd0, core_skew}, 32'h0000_00A5);
        check("core_thresh", {16'd0, core_thresh}, 32'h0000_5678);

        // Start, complete, clear
        wr(32'h00, 32'h7);
        check("start_pulse", {31'd0, core_start}, 32'd1);
        rd(32'h04, 32'h1, "status_busy");
        pulse_done(32'hDEAD_BEEF);
        rd(32'h04, 32'h2, "status_done");
        check("irq_set", {31'd0, irq}, 32'd1);
        rd(32'h10, 32'hDEAD_BEEF, "result");
        wr(32'h04, 32'h2);
        rd(32'h04, 32'h0, "status_w1c");
        check("irq_clr", {31'd0, irq}, 32'd0);

        // Overrun and watchdog timeout
        wr(32'h00, 32'h7);
        wr(32'h00, 32'h7);
        rd(32'h04, 32'h9, "status_ovr");
        idle(12);
        rd(32'h04, 32'h9, "busy_c15");
        rd(32'h04, 32'h9, "busy_c16");
        rd(32'h04, 32'hC, "status_timeout");
        rd(32'h10, 32'hDEAD_BEEF, "result_kept_to");
        wr(32'h04, 32'hC);
        rd(32'h04, 32'h0, "status_clr2");

        // Set beats W1C in the same cycle
        wr(32'h00, 32'h7);
        write_reg = 1; reg_waddr = 32'h04; reg_wdata = 32'h2;
        core_done = 1; core_result = 32'h1357_2468;
        @(negedge clk);
        write_reg = 0; core_done = 0; core_result = 0;
        rd(32'h04, 32'h2, "done_beats_w1c");
        rd(32'h10, 32'h1357_2468, "result2");

        // Read returns pre-write value
        rw(32'h0C, 32'h0000_9999, 32'h0000_5678, "rw_same");
        rd(32'h0C, 32'h0000_9999, "rw_after");

        // Ignored writes: unmapped, misaligned, RO, upper-bit alias
        wr(32'h14, 32'hFFFF_FFFF);
        wr(32'h02, 32'hFFFF_FFFF);
        wr(32'h10, 32'hFFFF_FFFF);
        wr(32'h20, 32'h0);
        rd(32'h00, 32'h5, "ign_ctrl");
        rd(32'h04, 32'h2, "ign_status");
        rd(32'h08, 32'hA5, "ign_skew");
        rd(32'h0C, 32'h9999, "ign_thresh");
        rd(32'h10, 32'h1357_2468, "ign_result");
        rd(32'h14, 32'h0, "unmapped_14");
        rd(32'h24, 32'h0, "unmapped_24");

        // Disable while busy, late done ignored, start with enable=0
        wr(32'h00, 32'h7);
        wr(32'h00, 32'h4);
        rd(32'h04, 32'h2, "disable_busy");
        pulse_done(32'hAAAA_5555);
        rd(32'h10, 32'h1357_2468, "late_done_ign");
        wr(32'h00, 32'h2);
        check("no_start_dis", {31'd0, core_start}, 32'd0);
        rd(32'h04, 32'h2, "status_dis");

        // Reset mid-job
        wr(32'h04, 32'hE);
        wr(32'h00, 32'h7);
        idle(1);
        rst = 1;
        idle(1);
        rst = 0;
        pulse_done(32'h0000_0055);
        rd(32'h04, 32'h0, "rst_job_status");
        rd(32'h10, 32'h0, "rst_job_result");
        check("rst_job_irq", {31'd0, irq}, 32'd0);
        rd(32'h00, 32'h0, "rst_job_ctrl");
        check("rst_job_en", {31'd0, core_enable}, 32'd0);

        idle(2);
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
